alu_branch_q: RTL and testbench

ALU_BRANCH_Q -- requirements
Module: alu_branch_q

---
 rtl/alu_branch_q.sv | 175 +++++++++++++++++
 tb/tb_alu_branch_q.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_branch_q.sv
// Compare/branch ALU with a DEPTH-entry result queue between issuer and committer.
// Optional build macro ALU_BRANCH_Q_MINMAX_EN enables MIN/MAX/MINU/MAXU on opcodes 8-11.
module alu_branch_q #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            cmd,
    input  logic [XLEN-1:0]       arg0,
    input  logic [XLEN-1:0]       arg1,
    input  logic [XLEN-1:0]       addr,
    input  logic [XLEN-1:0]       imm,
    input  logic [REG_ADDR_W-1:0] i_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_res,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_taken,
    output logic                  out_ovf,
    output logic                  out_illegal,
    input  logic                  flush,
    output logic                  busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]       r_res   [DEPTH];
    logic [REG_ADDR_W-1:0] r_rd    [DEPTH];
    logic [DEPTH-1:0]      r_taken;
    logic [DEPTH-1:0]      r_ovf;
    logic [DEPTH-1:0]      r_ill;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic [XLEN:0]         w_sum;
    logic                  w_lt_s;
    logic                  w_lt_u;
    logic                  w_eq;
    logic [XLEN-1:0]       w_res;
    logic                  w_taken;
    logic                  w_ovf;
    logic                  w_illegal;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            next_ptr = {PTR_W{1'b0}};
        end else begin
            next_ptr = ptr + PTR_W'(1);
        end
    endfunction

    assign w_sum  = {1'b0, addr} + {1'b0, imm};
    assign w_lt_s = $signed(arg0) < $signed(arg1);
    assign w_lt_u = arg0 < arg1;
    assign w_eq   = arg0 == arg1;

    // Operation decode and result selection
    always_comb begin
        w_res     = {XLEN{1'b0}};
        w_taken   = 1'b0;
        w_ovf     = 1'b0;
        w_illegal = 1'b0;
        case (cmd)
            4'd0: w_res = {{(XLEN-1){1'b0}}, w_lt_s};
            4'd1: w_res = {{(XLEN-1){1'b0}}, w_lt_u};
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
                w_res = w_sum[XLEN-1:0];
                w_ovf = w_sum[XLEN];
                case (cmd)
                    4'd2:    w_taken = w_eq;
                    4'd3:    w_taken = !w_eq;
                    4'd4:    w_taken = w_lt_s;
                    4'd5:    w_taken = !w_lt_s;
                    4'd6:    w_taken = w_lt_u;
                    4'd7:    w_taken = !w_lt_u;
                    default: w_taken = 1'b0;
                endcase
            end
`ifdef ALU_BRANCH_Q_MINMAX_EN
            4'd8:  w_res = w_lt_s ? arg0 : arg1;
            4'd9:  w_res = w_lt_s ? arg1 : arg0;
            4'd10: w_res = w_lt_u ? arg0 : arg1;
            4'd11: w_res = w_lt_u ? arg1 : arg0;
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == {CNT_W{1'b0}});
    // A pop never frees a slot for the same-cycle push: in_ready looks only at occupancy.
    assign w_push   = in_valid && !w_full && !flush;
    assign w_pop    = !w_empty && out_ready && !flush;
    assign in_ready = !w_full;
    assign busy     = !w_empty;
    assign out_valid = !w_empty;

    // Pointer and occupancy bookkeeping; flush overrides push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage, written at the push edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_res[i] <= {XLEN{1'b0}};
                r_rd[i]  <= {REG_ADDR_W{1'b0}};
            end
            r_taken <= {DEPTH{1'b0}};
            r_ovf   <= {DEPTH{1'b0}};
            r_ill   <= {DEPTH{1'b0}};
        end else if (w_push) begin
            r_res[r_wr_ptr]   <= w_res;
            r_rd[r_wr_ptr]    <= i_rd;
            r_taken[r_wr_ptr] <= w_taken;
            r_ovf[r_wr_ptr]   <= w_ovf;
            r_ill[r_wr_ptr]   <= w_illegal;
        end else begin
            r_taken <= r_taken;
        end
    end

    // Head fields are forced to zero while the queue is empty
    always_comb begin
        if (!w_empty) begin
            out_res     = r_res[r_rd_ptr];
            out_rd      = r_rd[r_rd_ptr];
            out_taken   = r_taken[r_rd_ptr];
            out_ovf     = r_ovf[r_rd_ptr];
            out_illegal = r_ill[r_rd_ptr];
        end else begin
            out_res     = {XLEN{1'b0}};
            out_rd      = {REG_ADDR_W{1'b0}};
            out_taken   = 1'b0;
            out_ovf     = 1'b0;
            out_illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_branch_q.sv
// Self-checking bench for alu_branch_q: queue-based reference model plus literal pins.
module tb_alu_branch_q;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cmd;
    logic [31:0] arg0, arg1, addr, imm;
    logic [4:0]  i_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [4:0]  out_rd;
    logic        out_taken, out_ovf, out_illegal;
    logic        flush;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        taken;
        logic        ovf;
        logic        ill;
    } ent_t;

    ent_t q[$];

    alu_branch_q #(.XLEN(32), .REG_ADDR_W(5), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cmd(cmd), .arg0(arg0), .arg1(arg1), .addr(addr), .imm(imm), .i_rd(i_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_rd(out_rd), .out_taken(out_taken), .out_ovf(out_ovf),
        .out_illegal(out_illegal), .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic ent_t expect_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] pc, input logic [31:0] off, input logic [4:0] rd);
        ent_t e;
        longint unsigned sum;
        int signed sa, sb;
        sa = a;
        sb = b;
        sum = longint'(pc) + longint'(off);
        e = '0;
        e.rd = rd;
        if (c >= 4'd2 && c <= 4'd7) begin
            e.res = sum[31:0];
            e.ovf = (sum >= 64'h1_0000_0000);
        end
        case (c)
            4'd0: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd1: e.res = (a < b) ? 32'd1 : 32'd0;
            4'd2: e.taken = (a == b);
            4'd3: e.taken = (a != b);
            4'd4: e.taken = (sa < sb);
            4'd5: e.taken = (sa >= sb);
            4'd6: e.taken = (a < b);
            4'd7: e.taken = (a >= b);
`ifdef ALU_BRANCH_Q_MINMAX_EN
            4'd8:  e.res = (sa <= sb) ? a : b;
            4'd9:  e.res = (sa >= sb) ? a : b;
            4'd10: e.res = (a <= b) ? a : b;
            4'd11: e.res = (a >= b) ? a : b;
`endif
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        ent_t h;
        h = (q.size() != 0) ? q[0] : '0;
        chk("in_ready", in_ready, q.size() < 4);
        chk("out_valid", out_valid, q.size() != 0);
        chk("busy", busy, q.size() != 0);
        chk("out_res", out_res, h.res);
        chk("out_rd", out_rd, h.rd);
        chk("out_taken", out_taken, h.taken);
        chk("out_ovf", out_ovf, h.ovf);
        chk("out_illegal", out_illegal, h.ill);
    endtask

    // One clock: model sees the same inputs as the DUT edge, then check at the falling edge.
    task automatic tick();
        bit pop, push;
        @(posedge clk);
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            pop  = (q.size() != 0) && out_ready;
            push = in_valid && (q.size() < 4);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(expect_op(cmd, arg0, arg1, addr, imm, i_rd));
        end
        @(negedge clk);
        compare();
    endtask

    task automatic set_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] off, input logic [4:0] rd);
        in_valid = 1'b1; cmd = c; arg0 = a; arg1 = b; addr = pc; imm = off; i_rd = rd;
    endtask

    task automatic idle();
        in_valid = 1'b0; cmd = 4'd0; arg0 = 32'd0; arg1 = 32'd0; addr = 32'd0; imm = 32'd0; i_rd = 5'd0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_res", out_res, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic compare/branch results with a draining committer
        out_ready = 1'b1;
        set_op(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd1);
        tick();
        chk("slt_valid", out_valid, 1'b1);
        chk("slt_res", out_res, 32'd1);
        chk("slt_taken", out_taken, 1'b0);
        set_op(4'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd2);
        tick();
        chk("sltu_res", out_res, 32'd0);
        chk("sltu_rd", out_rd, 5'd2);
        set_op(4'd4, 32'hFFFF_FFFE, 32'd3, 32'h100, 32'hFFFF_FFF0, 5'd3);
        tick();
        chk("blt_valid", out_valid, 1'b1);
        chk("blt_res", out_res, 32'hF0);
        chk("blt_ovf", out_ovf, 1'b1);
        chk("blt_taken", out_taken, 1'b1);
        set_op(4'd9, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd4);
        tick();
`ifdef ALU_BRANCH_Q_MINMAX_EN
        chk("max_res", out_res, 32'd5);
        chk("max_ill", out_illegal, 1'b0);
`else
        chk("max_res", out_res, 32'd0);
        chk("max_ill", out_illegal, 1'b1);
`endif
        set_op(4'd2, 32'd7, 32'd7, 32'h1000, 32'h24, 5'd5);  tick();
        set_op(4'd3, 32'd7, 32'd7, 32'h1000, 32'h24, 5'd6);  tick();
        set_op(4'd5, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'd1, 5'd7); tick();
        chk("bge_res", out_res, 32'd0);
        chk("bge_ovf", out_ovf, 1'b1);
        chk("bge_taken", out_taken, 1'b0);
        set_op(4'd6, 32'd1, 32'h8000_0000, 32'h10, 32'h20, 5'd8); tick();
        set_op(4'd7, 32'd1, 32'd1, 32'h7FFF_FFFF, 32'd1, 5'd9);   tick();
        set_op(4'd8, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 5'd10);  tick();
        set_op(4'd10, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 5'd11); tick();
        set_op(4'd11, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 5'd12); tick();
        set_op(4'd12, 32'd9, 32'd9, 32'h40, 32'h40, 5'd13); tick();
        chk("ill_res", out_res, 32'd0);
        chk("ill_flag", out_illegal, 1'b1);
        set_op(4'd15, 32'd1, 32'd2, 32'h40, 32'h40, 5'd14); tick();
        idle();
        tick();
        chk("empty_valid", out_valid, 1'b0);
        chk("empty_res", out_res, 32'd0);

        // Fill to DEPTH with the committer stalled; fifth op must be held
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_op(4'd0, 32'(i), 32'd3, 32'd0, 32'd0, 5'(i));
            tick();
        end
        chk("full_in_ready", in_ready, 1'b0);
        set_op(4'd1, 32'd0, 32'd1, 32'd0, 32'd0, 5'd21);
        tick();
        tick();
        chk("full_head_rd", out_rd, 5'd1);
        idle();
        out_ready = 1'b1;
        tick();
        chk("pop_in_ready", in_ready, 1'b1);
        chk("pop_head_rd", out_rd, 5'd2);
        tick(); tick(); tick();
        chk("drained", out_valid, 1'b0);

        // Flush with three queued and an op presented
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(4'd2, 32'd1, 32'd1, 32'd4, 32'(i), 5'(i + 16));
            tick();
        end
        set_op(4'd3, 32'd1, 32'd2, 32'd8, 32'd8, 5'd30);
        flush = 1'b1;
        tick();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_busy", busy, 1'b0);
        flush = 1'b0;
        idle();
        tick();
        chk("flush_lost", out_valid, 1'b0);

        // Reset with two queued
        set_op(4'd0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd3); tick();
        set_op(4'd0, 32'd2, 32'd1, 32'd0, 32'd0, 5'd4); tick();
        idle();
        rst_n = 1'b0;
        q.delete();
        #1;
        compare();
        chk("rst_mid_valid", out_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_rel_ready", in_ready, 1'b1);
        chk("rst_rel_busy", busy, 1'b0);

        // Mixed traffic with a toggling committer
        for (int i = 0; i < 40; i++) begin
            set_op(4'(i % 16), 32'(i * 32'h1357_9BDF), 32'(32'hFEDC_BA98 - i * 7), 32'(i * 32'h0800_0000), 32'(32'hF800_0000 + i), 5'(i));
            in_valid  = (i % 3) != 2;
            out_ready = (i % 5) < 2;
            tick();
        end
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
